// File: rtl/rv_arb_pkg.sv
// rv_arb_pkg: shared types for the unified-memory arbiter.
// Holds the response-owner encoding, the data-request record carried
// through the optional skid, and the width of the fairness burst counter.

package rv_arb_pkg;

    // Who owns the read data returning from the memory in the next cycle
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2,
        OWN_STORE = 2'd3
    } owner_e;

    // One load/store request from the data side
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        is_store;
    } dm_req_t;

    localparam int BURST_CNT_W = 4;

    // Owner code for a granted data request
    function automatic owner_e dataOwner(input logic isStore);
        return isStore ? OWN_STORE : OWN_LOAD;
    endfunction

endpackage

// File: rtl/rv_arb_skid.sv
// rv_arb_skid: one-entry holding register for a data strobe that was
// deferred so that fetch could take a slot. Only exists when the
// arbiter is built with URV_ARB_FAIR_EN.

`ifdef URV_ARB_FAIR_EN
module rv_arb_skid
    import rv_arb_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_load,
    input  logic    i_drain,
    input  dm_req_t i_req,
    output dm_req_t o_req,
    output logic    o_full
);

    dm_req_t r_req;
    logic    r_full;

    // Capture a deferred request, release it once the arbiter grants it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_req  <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_req  <= i_req;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_req  = r_req;
    assign o_full = r_full;

endmodule
`endif

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one single-port, 1-cycle-latency memory between
// instruction fetch and the load/store unit. Data wins; fetch is stalled
// by withholding im_valid_o. A registered owner code routes each read
// response back to whoever was granted the previous cycle.
// Optional build macro URV_ARB_FAIR_EN adds a burst counter and one-entry
// skid so fetch is guaranteed a slot after MAX_DATA_BURST data grants.

module rv_mem_arbiter
    import rv_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_i,
    input  logic [3:0]  dm_sel_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic [31:0] dm_data_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_busy_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wsel_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rdata_i
);

    if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 15) begin : g_badBurstParam
        $error("rv_mem_arbiter: MAX_DATA_BURST must be in 1..15");
    end

    dm_req_t w_liveReq;
    logic    w_liveStrobe;
    logic    w_grantData;
    dm_req_t w_grantReq;
    owner_e  w_grantOwner;
    owner_e  r_owner;

    // A store strobe wins over a simultaneous load strobe
    assign w_liveReq    = '{addr: dm_addr_i, wdata: dm_data_i, sel: dm_sel_i, is_store: dm_store_i};
    assign w_liveStrobe = dm_load_i | dm_store_i;

`ifdef URV_ARB_FAIR_EN
    logic                   w_skidFull;
    logic                   w_skidLoad;
    logic                   w_skidDrain;
    dm_req_t                w_skidReq;
    logic                   w_burstLimit;
    logic [BURST_CNT_W-1:0] r_burstCnt;

    assign w_burstLimit = (r_burstCnt == BURST_CNT_W'(MAX_DATA_BURST));

    // Grant order: pending skid, then a live strobe unless the burst limit
    // diverts it into the skid, otherwise fetch
    always_comb begin
        w_grantData = 1'b0;
        w_grantReq  = w_liveReq;
        w_skidLoad  = 1'b0;
        w_skidDrain = 1'b0;
        if (w_skidFull) begin
            w_grantData = 1'b1;
            w_grantReq  = w_skidReq;
            w_skidDrain = 1'b1;
        end else if (w_liveStrobe && w_burstLimit) begin
            w_skidLoad = 1'b1;
        end else if (w_liveStrobe) begin
            w_grantData = 1'b1;
        end
    end

    // Count consecutive data grants; any fetch grant restarts the run
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_burstCnt <= '0;
        end else if (w_grantData) begin
            r_burstCnt <= r_burstCnt + BURST_CNT_W'(1);
        end else begin
            r_burstCnt <= '0;
        end
    end

    rv_arb_skid u_skid (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_load  (w_skidLoad),
        .i_drain (w_skidDrain),
        .i_req   (w_liveReq),
        .o_req   (w_skidReq),
        .o_full  (w_skidFull)
    );

    assign dm_busy_o = w_skidFull & ~rst_i;

    a_noStrobeWhileBusy : assert property (
        @(posedge clk_i) disable iff (rst_i) !(dm_busy_o && w_liveStrobe)
    );
`else
    assign w_grantData = w_liveStrobe;
    assign w_grantReq  = w_liveReq;
    assign dm_busy_o   = 1'b0;
`endif

    assign w_grantOwner = w_grantData ? dataOwner(w_grantReq.is_store) : OWN_FETCH;

    assign mem_addr_o  = w_grantData ? w_grantReq.addr : im_addr_i;
    assign mem_wdata_o = w_grantReq.wdata;
    assign mem_wsel_o  = (w_grantOwner == OWN_STORE) ? w_grantReq.sel : 4'b0000;
    assign mem_we_o    = (w_grantOwner == OWN_STORE) && !rst_i;

    // Remember who was granted so next cycle's response is routed to them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_grantOwner;
        end
    end

    assign im_data_o       = mem_rdata_i;
    assign dm_data_o       = mem_rdata_i;
    assign im_valid_o      = !rst_i && (r_owner == OWN_FETCH);
    assign dm_load_done_o  = !rst_i && (r_owner == OWN_LOAD);
    assign dm_store_done_o = !rst_i && (r_owner == OWN_STORE);

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: bench for rv_mem_arbiter with a behavioural memory
// macro and a request-level reference model. Builds with or without
// URV_ARB_FAIR_EN; the arbiter is instantiated with MAX_DATA_BURST = 2.

`timescale 1ns/1ps

module tb_rv_mem_arbiter;

    localparam int MAX_BURST = 2;
`ifdef URV_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] im_addr_i;
    logic [31:0] im_data_o;
    logic        im_valid_o;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_i;
    logic [3:0]  dm_sel_i;
    logic        dm_load_i;
    logic        dm_store_i;
    logic [31:0] dm_data_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        dm_busy_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wsel_o;
    logic        mem_we_o;
    logic [31:0] mem_rdata_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] memArr   [256];
    logic [31:0] modelMem [256];

    always #5 clk_i = ~clk_i;

    rv_mem_arbiter #(.MAX_DATA_BURST(MAX_BURST)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .im_addr_i       (im_addr_i),
        .im_data_o       (im_data_o),
        .im_valid_o      (im_valid_o),
        .dm_addr_i       (dm_addr_i),
        .dm_data_i       (dm_data_i),
        .dm_sel_i        (dm_sel_i),
        .dm_load_i       (dm_load_i),
        .dm_store_i      (dm_store_i),
        .dm_data_o       (dm_data_o),
        .dm_load_done_o  (dm_load_done_o),
        .dm_store_done_o (dm_store_done_o),
        .dm_busy_o       (dm_busy_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wsel_o      (mem_wsel_o),
        .mem_we_o        (mem_we_o),
        .mem_rdata_i     (mem_rdata_i)
    );

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = oldW;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = newW[b*8 +: 8];
        end
        return r;
    endfunction

    // Single-port synchronous memory macro, read-first, 1-cycle latency
    always @(posedge clk_i) begin
        if (mem_we_o) memArr[mem_addr_o[9:2]] <= mergeBytes(memArr[mem_addr_o[9:2]], mem_wdata_o, mem_wsel_o);
        mem_rdata_i <= memArr[mem_addr_o[9:2]];
    end

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i      = 1'b1;
        dm_store_i = 1'b1;
        dm_addr_i  = 32'h4;
        dm_data_i  = 32'h1234_5678;
        dm_sel_i   = 4'hF;
        nextCycle();
        nextCycle();
        @(negedge clk_i);
        total++; if (mem_we_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%b exp=0", mem_we_o); end
        total++; if (im_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_imvalid got=%b exp=0", im_valid_o); end
        total++; if (dm_load_done_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_loaddone got=%b exp=0", dm_load_done_o); end
        total++; if (dm_store_done_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_storedone got=%b exp=0", dm_store_done_o); end
        total++; if (dm_busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", dm_busy_o); end
        total++; if (im_data_o !== mem_rdata_i) begin bad++; $display("[TB] FAIL reset_imdata got=%h exp=%h", im_data_o, mem_rdata_i); end
        total++; if (dm_data_o !== mem_rdata_i) begin bad++; $display("[TB] FAIL reset_dmdata got=%h exp=%h", dm_data_o, mem_rdata_i); end
        dm_store_i = 1'b0;
        dm_sel_i   = 4'h0;
        nextCycle();
        total++; if (memArr[1] !== modelMem[1]) begin bad++; $display("[TB] FAIL reset_nowrite got=%h exp=%h", memArr[1], modelMem[1]); end
        rst_i = 1'b0;
    endtask

    task automatic test_fetch_only();
        for (int i = 0; i < 4; i++) begin
            im_addr_i = 32'(i * 4);
            @(negedge clk_i);
            total++; if (mem_addr_o !== 32'(i * 4)) begin bad++; $display("[TB] FAIL fetch_addr%0d got=%h exp=%h", i, mem_addr_o, i * 4); end
            total++; if (im_valid_o !== (i > 0)) begin bad++; $display("[TB] FAIL fetch_valid%0d got=%b exp=%b", i, im_valid_o, i > 0); end
            if (i > 0) begin
                total++; if (im_data_o !== modelMem[i-1]) begin bad++; $display("[TB] FAIL fetch_data%0d got=%h exp=%h", i, im_data_o, modelMem[i-1]); end
            end
            total++; if ({dm_load_done_o, dm_store_done_o, mem_we_o} !== 3'b000) begin bad++; $display("[TB] FAIL fetch_noflags%0d got=%b exp=000", i, {dm_load_done_o, dm_store_done_o, mem_we_o}); end
            nextCycle();
        end
    endtask

    task automatic test_load_collision();
        im_addr_i = 32'h8;
        dm_addr_i = 32'h40;
        dm_load_i = 1'b1;
        @(negedge clk_i);
        total++; if (mem_addr_o !== 32'h40) begin bad++; $display("[TB] FAIL coll_grantaddr got=%h exp=40", mem_addr_o); end
        total++; if (im_data_o !== modelMem[3] || im_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL coll_prevfetch got=%b/%h exp=1/%h", im_valid_o, im_data_o, modelMem[3]); end
        nextCycle();
        dm_load_i = 1'b0;
        @(negedge clk_i);
        total++; if (dm_load_done_o !== 1'b1) begin bad++; $display("[TB] FAIL coll_done got=%b exp=1", dm_load_done_o); end
        total++; if (dm_data_o !== modelMem[16]) begin bad++; $display("[TB] FAIL coll_data got=%h exp=%h", dm_data_o, modelMem[16]); end
        total++; if (im_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL coll_stall got=%b exp=0", im_valid_o); end
        total++; if (mem_addr_o !== 32'h8) begin bad++; $display("[TB] FAIL coll_refetch got=%h exp=8", mem_addr_o); end
        nextCycle();
        @(negedge clk_i);
        total++; if (im_valid_o !== 1'b1 || im_data_o !== modelMem[2]) begin bad++; $display("[TB] FAIL coll_fetchdata got=%b/%h exp=1/%h", im_valid_o, im_data_o, modelMem[2]); end
        total++; if (dm_load_done_o !== 1'b0) begin bad++; $display("[TB] FAIL coll_donedrop got=%b exp=0", dm_load_done_o); end
        nextCycle();
    endtask

    task automatic test_store();
        dm_store_i = 1'b1;
        dm_addr_i  = 32'h80;
        dm_data_i  = 32'hDEAD_BEEF;
        dm_sel_i   = 4'h3;
        @(negedge clk_i);
        total++; if (mem_we_o !== 1'b1) begin bad++; $display("[TB] FAIL store_we got=%b exp=1", mem_we_o); end
        total++; if (mem_wsel_o !== 4'h3) begin bad++; $display("[TB] FAIL store_wsel got=%h exp=3", mem_wsel_o); end
        total++; if (mem_addr_o !== 32'h80 || mem_wdata_o !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL store_bus got=%h/%h exp=80/deadbeef", mem_addr_o, mem_wdata_o); end
        modelMem[32] = mergeBytes(modelMem[32], 32'hDEAD_BEEF, 4'h3);
        nextCycle();
        dm_store_i = 1'b0;
        dm_sel_i   = 4'h0;
        dm_load_i  = 1'b1;
        @(negedge clk_i);
        total++; if (dm_store_done_o !== 1'b1) begin bad++; $display("[TB] FAIL store_done got=%b exp=1", dm_store_done_o); end
        total++; if ({dm_load_done_o, im_valid_o} !== 2'b00) begin bad++; $display("[TB] FAIL store_otherflags got=%b exp=00", {dm_load_done_o, im_valid_o}); end
        total++; if (mem_we_o !== 1'b0 || mem_wsel_o !== 4'h0) begin bad++; $display("[TB] FAIL load_nowrite got=%b/%h exp=0/0", mem_we_o, mem_wsel_o); end
        nextCycle();
        dm_load_i = 1'b0;
        @(negedge clk_i);
        total++; if (dm_load_done_o !== 1'b1 || dm_data_o !== modelMem[32]) begin bad++; $display("[TB] FAIL readback got=%b/%h exp=1/%h", dm_load_done_o, dm_data_o, modelMem[32]); end
        total++; if (dm_data_o[15:0] !== 16'hBEEF) begin bad++; $display("[TB] FAIL readback_half got=%h exp=beef", dm_data_o[15:0]); end
        nextCycle();
    endtask

    task automatic test_reset_mid_read();
        im_addr_i = 32'hC;
        @(negedge clk_i);
        total++; if (mem_addr_o !== 32'hC) begin bad++; $display("[TB] FAIL rstmid_grant got=%h exp=c", mem_addr_o); end
        nextCycle();
        rst_i      = 1'b1;
        dm_store_i = 1'b1;
        dm_addr_i  = 32'h90;
        dm_data_i  = 32'hCAFE_F00D;
        dm_sel_i   = 4'hF;
        @(negedge clk_i);
        total++; if ({im_valid_o, dm_load_done_o, dm_store_done_o, dm_busy_o} !== 4'b0000) begin bad++; $display("[TB] FAIL rstmid_flags got=%b exp=0000", {im_valid_o, dm_load_done_o, dm_store_done_o, dm_busy_o}); end
        total++; if (mem_we_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_we got=%b exp=0", mem_we_o); end
        nextCycle();
        rst_i      = 1'b0;
        dm_store_i = 1'b0;
        dm_sel_i   = 4'h0;
        im_addr_i  = 32'h10;
        @(negedge clk_i);
        total++; if ({im_valid_o, dm_store_done_o} !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_nopulse got=%b exp=00", {im_valid_o, dm_store_done_o}); end
        total++; if (memArr[36] !== modelMem[36]) begin bad++; $display("[TB] FAIL rstmid_nowrite got=%h exp=%h", memArr[36], modelMem[36]); end
        nextCycle();
        @(negedge clk_i);
        total++; if (im_valid_o !== 1'b1 || im_data_o !== modelMem[4]) begin bad++; $display("[TB] FAIL rstmid_firstvalid got=%b/%h exp=1/%h", im_valid_o, im_data_o, modelMem[4]); end
        nextCycle();
    endtask

    task automatic test_burst();
`ifdef URV_ARB_FAIR_EN
        bit          strobeTab[7]  = '{1, 1, 1, 0, 1, 0, 0};
        logic [31:0] addrTab[7]    = '{32'h20, 32'h24, 32'h28, 32'h0, 32'h2C, 32'h0, 32'h0};
        logic [31:0] memAddrTab[7] = '{32'h20, 32'h24, 32'h10, 32'h28, 32'h2C, 32'h10, 32'h10};
        bit          busyTab[7]    = '{0, 0, 0, 1, 0, 0, 0};
        int          doneTab[7]    = '{-1, 8, 9, -1, 10, 11, -1};
        bit          imvTab[7]     = '{1, 0, 0, 1, 0, 0, 1};
`else
        bit          strobeTab[5]  = '{1, 1, 1, 1, 0};
        logic [31:0] addrTab[5]    = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h0};
        logic [31:0] memAddrTab[5] = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h10};
        bit          busyTab[5]    = '{0, 0, 0, 0, 0};
        int          doneTab[5]    = '{-1, 8, 9, 10, 11};
        bit          imvTab[5]     = '{1, 0, 0, 0, 0};
`endif
        im_addr_i = 32'h10;
        for (int c = 0; c < $size(strobeTab); c++) begin
            dm_load_i = strobeTab[c];
            dm_addr_i = addrTab[c];
            @(negedge clk_i);
            total++; if (mem_addr_o !== memAddrTab[c]) begin bad++; $display("[TB] FAIL burst_addr%0d got=%h exp=%h", c, mem_addr_o, memAddrTab[c]); end
            total++; if (dm_busy_o !== busyTab[c]) begin bad++; $display("[TB] FAIL burst_busy%0d got=%b exp=%b", c, dm_busy_o, busyTab[c]); end
            total++; if (dm_load_done_o !== (doneTab[c] >= 0)) begin bad++; $display("[TB] FAIL burst_done%0d got=%b exp=%b", c, dm_load_done_o, doneTab[c] >= 0); end
            if (doneTab[c] >= 0) begin
                total++; if (dm_data_o !== modelMem[doneTab[c]]) begin bad++; $display("[TB] FAIL burst_data%0d got=%h exp=%h", c, dm_data_o, modelMem[doneTab[c]]); end
            end
            total++; if (im_valid_o !== imvTab[c]) begin bad++; $display("[TB] FAIL burst_imvalid%0d got=%b exp=%b", c, im_valid_o, imvTab[c]); end
            if (imvTab[c]) begin
                total++; if (im_data_o !== modelMem[4]) begin bad++; $display("[TB] FAIL burst_imdata%0d got=%h exp=%h", c, im_data_o, modelMem[4]); end
            end
            nextCycle();
        end
        dm_load_i = 1'b0;
    endtask

    task automatic test_random();
        int          dataRun   = 0;
        bit          skidValid = 1'b0;
        logic [31:0] skidAddr  = '0;
        logic [31:0] skidWdata = '0;
        logic [3:0]  skidSel   = '0;
        bit          skidStore = 1'b0;
        int          prevKind  = 1;
        logic [31:0] prevData  = modelMem[4];
        bit          modelBusy;
        int          kind;
        bit          strobe;
        bit          isStore;
        int          gKind;
        logic [31:0] gAddr;
        logic [31:0] gWdata;
        logic [3:0]  gSel;
        for (int n = 0; n < 400; n++) begin
            modelBusy  = FAIR && skidValid;
            kind       = modelBusy ? 0 : int'($urandom_range(0, 5));
            im_addr_i  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            dm_addr_i  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            dm_data_i  = $urandom;
            dm_sel_i   = 4'($urandom_range(1, 15));
            dm_load_i  = (kind == 3) || (kind == 5);
            dm_store_i = (kind >= 4);
            strobe     = (kind >= 3);
            isStore    = (kind >= 4);
            if (FAIR && skidValid) begin
                gKind = skidStore ? 3 : 2; gAddr = skidAddr; gWdata = skidWdata; gSel = skidSel;
                skidValid = 1'b0;
                dataRun++;
            end else if (strobe && FAIR && dataRun == MAX_BURST) begin
                gKind = 1; gAddr = im_addr_i; gWdata = '0; gSel = '0;
                skidValid = 1'b1; skidAddr = dm_addr_i; skidWdata = dm_data_i; skidSel = dm_sel_i; skidStore = isStore;
                dataRun = 0;
            end else if (strobe) begin
                gKind = isStore ? 3 : 2; gAddr = dm_addr_i; gWdata = dm_data_i; gSel = dm_sel_i;
                dataRun++;
            end else begin
                gKind = 1; gAddr = im_addr_i; gWdata = '0; gSel = '0;
                dataRun = 0;
            end
            @(negedge clk_i);
            total++; if (mem_addr_o !== gAddr) begin bad++; $display("[TB] FAIL rnd_addr n=%0d got=%h exp=%h", n, mem_addr_o, gAddr); end
            total++; if (mem_we_o !== (gKind == 3)) begin bad++; $display("[TB] FAIL rnd_we n=%0d got=%b exp=%b", n, mem_we_o, gKind == 3); end
            total++; if (mem_wsel_o !== ((gKind == 3) ? gSel : 4'h0)) begin bad++; $display("[TB] FAIL rnd_wsel n=%0d got=%h exp=%h", n, mem_wsel_o, (gKind == 3) ? gSel : 4'h0); end
            if (gKind == 3) begin
                total++; if (mem_wdata_o !== gWdata) begin bad++; $display("[TB] FAIL rnd_wdata n=%0d got=%h exp=%h", n, mem_wdata_o, gWdata); end
            end
            total++; if (dm_busy_o !== modelBusy) begin bad++; $display("[TB] FAIL rnd_busy n=%0d got=%b exp=%b", n, dm_busy_o, modelBusy); end
            total++; if ({im_valid_o, dm_load_done_o, dm_store_done_o} !== {prevKind == 1, prevKind == 2, prevKind == 3}) begin
                bad++; $display("[TB] FAIL rnd_flags n=%0d got=%b exp=%b", n, {im_valid_o, dm_load_done_o, dm_store_done_o}, {prevKind == 1, prevKind == 2, prevKind == 3});
            end
            if (prevKind == 1) begin
                total++; if (im_data_o !== prevData) begin bad++; $display("[TB] FAIL rnd_imdata n=%0d got=%h exp=%h", n, im_data_o, prevData); end
            end
            if (prevKind == 2) begin
                total++; if (dm_data_o !== prevData) begin bad++; $display("[TB] FAIL rnd_dmdata n=%0d got=%h exp=%h", n, dm_data_o, prevData); end
            end
            prevKind = gKind;
            prevData = modelMem[gAddr[9:2]];
            if (gKind == 3) modelMem[gAddr[9:2]] = mergeBytes(modelMem[gAddr[9:2]], gWdata, gSel);
            nextCycle();
        end
        dm_load_i  = 1'b0;
        dm_store_i = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b1;
        im_addr_i  = '0;
        dm_addr_i  = '0;
        dm_data_i  = '0;
        dm_sel_i   = '0;
        dm_load_i  = 1'b0;
        dm_store_i = 1'b0;
        for (int i = 0; i < 256; i++) begin
            memArr[i]   <= 32'h100 + 32'(i * 4);
            modelMem[i]  = 32'h100 + 32'(i * 4);
        end
        $display("[TB] starting, fair mode = %0d", FAIR);
        test_reset();
        test_fetch_only();
        test_load_collision();
        test_store();
        test_reset_mid_read();
        test_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
